iic_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one IIC master driver among `N_REQ` requesters, for example an EEPROM test, a sensor config loader and a debug port. It sits between the requesters and the driver:
- latches the winner's command;
- issues one `iic_exec` pulse aligned to the driver's divided state clock;
- watches `iic_done` and returns read data, ack status and a completion pulse to the winner only;
- a watchdog aborts transactions the driver never finishes.

---
 rtl/iic_pkg.sv | 15 +
 rtl/rr_pick.sv | 31 +++
 rtl/iic_arbiter.sv | 157 +++++++++++++++
 tb/tb_iic_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the IIC arbiter: FSM state encoding and command field widths.
package iic_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [4:0] {
        StIdle   = 5'b00001,
        StArm    = 5'b00010,
        StLaunch = 5'b00100,
        StBusy   = 5'b01000,
        StResp   = 5'b10000
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit after the previous winner.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             valid
);

    logic [IDX_W-1:0] idx;

    // Scan last+1 .. last+N_REQ; the final candidate is 'last' itself.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        idx        = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((32'(last) + k) % N_REQ);
            if (!valid && req[idx]) begin
                valid       = 1'b1;
                winner_idx  = idx;
                winner[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iic_arbiter.sv
// Round-robin arbiter and sequencer sharing one IIC master driver among N_REQ requesters,
// with tick-aligned launch, result return to the winner and a watchdog abort.
module iic_arbiter
    import iic_pkg::*;
#(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned TIMEOUT_TICKS = 1024
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_rh_wl,
    input  logic [N_REQ-1:0]        req_bit_ctrl,
    input  logic [ADDR_W*N_REQ-1:0] req_addr,
    input  logic [DATA_W*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        req_done,
    output logic [DATA_W-1:0]       rdata,
    output logic                    nack,
    output logic                    timeout,
    input  logic                    dri_tick_clk,
    output logic                    iic_exec,
    output logic                    iic_rh_wl,
    output logic                    iic_bit_ctrl,
    output logic [ADDR_W-1:0]       iic_addr,
    output logic [DATA_W-1:0]       iic_data_w,
    input  logic [DATA_W-1:0]       iic_data_r,
    input  logic                    iic_ack,
    input  logic                    iic_done
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_TICKS + 1);

    state_t           state_q;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] win_idx_q;
    logic [WD_W-1:0]  wdog_q;
    logic [WD_W-1:0]  wdog_inc;

    logic tick_sync_q, tick_prev_q, done_sync_q, done_prev_q;
    logic tick, done_rise;

    logic [N_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last       (last_q),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    assign pick_addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
    assign pick_wdata = req_wdata[pick_idx*DATA_W +: DATA_W];

    // The driver clock and done flag come from another clock phase; treat both as data.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tick_sync_q <= 1'b0;
            tick_prev_q <= 1'b0;
            done_sync_q <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            tick_sync_q <= dri_tick_clk;
            tick_prev_q <= tick_sync_q;
            done_sync_q <= iic_done;
            done_prev_q <= done_sync_q;
        end
    end

    assign tick      = tick_sync_q & ~tick_prev_q;
    assign done_rise = done_sync_q & ~done_prev_q;
    assign wdog_inc  = (wdog_q == '1) ? wdog_q : wdog_q + WD_W'(1);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= StIdle;
            last_q       <= IDX_W'(N_REQ - 1);
            win_idx_q    <= '0;
            wdog_q       <= '0;
            gnt          <= '0;
            req_done     <= '0;
            rdata        <= '0;
            nack         <= 1'b0;
            timeout      <= 1'b0;
            iic_exec     <= 1'b0;
            iic_rh_wl    <= 1'b0;
            iic_bit_ctrl <= 1'b0;
            iic_addr     <= '0;
            iic_data_w   <= '0;
        end else begin
            req_done <= '0;
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        gnt          <= pick_onehot;
                        win_idx_q    <= pick_idx;
                        iic_rh_wl    <= req_rh_wl[pick_idx];
                        iic_bit_ctrl <= req_bit_ctrl[pick_idx];
                        iic_addr     <= pick_addr;
                        iic_data_w   <= pick_wdata;
                        state_q      <= StArm;
                    end
                end
                StArm: begin
                    if (tick) begin
                        iic_exec <= 1'b1;
                        state_q  <= StLaunch;
                    end
                end
                StLaunch: begin
                    // Drop exec on the next tick so the driver sees exactly one rising edge.
                    if (tick) begin
                        iic_exec <= 1'b0;
                        wdog_q   <= '0;
                        state_q  <= StBusy;
                    end
                end
                StBusy: begin
                    if (done_rise) begin
                        if (iic_rh_wl) begin
                            rdata <= iic_data_r;
                        end
                        nack    <= iic_ack;
                        timeout <= 1'b0;
                        state_q <= StResp;
                    end else if (tick) begin
                        wdog_q <= wdog_inc;
                        if (wdog_inc == WD_W'(TIMEOUT_TICKS)) begin
                            timeout <= 1'b1;
                            nack    <= 1'b1;
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    req_done <= gnt;
                    gnt      <= '0;
                    last_q   <= win_idx_q;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_arbiter.sv
// Directed bench for iic_arbiter with a behavioural IIC driver model and tick generator.
module tb_iic_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  req_rh_wl = '0;
    logic [3:0]  req_bit_ctrl = '0;
    logic [63:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  gnt;
    logic [3:0]  req_done;
    logic [7:0]  rdata;
    logic        nack;
    logic        timeout;
    logic        dri_tick_clk = 1'b0;
    logic        iic_exec;
    logic        iic_rh_wl;
    logic        iic_bit_ctrl;
    logic [15:0] iic_addr;
    logic [7:0]  iic_data_w;
    logic [7:0]  iic_data_r = '0;
    logic        iic_ack = 1'b0;
    logic        iic_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Environment bookkeeping shared with the stimulus process.
    int         tick_cnt = 0;
    int         exec_rises = 0;
    int         exec_ticks = 0;
    int         exec_fall_tick = 0;
    bit         model_en = 1'b1;
    logic [7:0] model_rdata = '0;
    logic       model_ack = 1'b0;

    int         e_rises0;
    int         e_ticks0;
    logic [3:0] exp_g;

    iic_arbiter #(
        .N_REQ         (4),
        .TIMEOUT_TICKS (16)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .req          (req),
        .req_rh_wl    (req_rh_wl),
        .req_bit_ctrl (req_bit_ctrl),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .req_done     (req_done),
        .rdata        (rdata),
        .nack         (nack),
        .timeout      (timeout),
        .dri_tick_clk (dri_tick_clk),
        .iic_exec     (iic_exec),
        .iic_rh_wl    (iic_rh_wl),
        .iic_bit_ctrl (iic_bit_ctrl),
        .iic_addr     (iic_addr),
        .iic_data_w   (iic_data_w),
        .iic_data_r   (iic_data_r),
        .iic_ack      (iic_ack),
        .iic_done     (iic_done)
    );

    always #5 sys_clk = ~sys_clk;

    // Tick generator (period 8 sys cycles), exec monitor and driver model.
    initial begin : env
        int unsigned div;
        logic        exec_prev;
        int          delay;
        int          hold;
        div       = 0;
        exec_prev = 1'b0;
        delay     = -1;
        hold      = 0;
        forever begin
            @(posedge sys_clk);
            #1;
            div++;
            if (div % 8 == 0) begin
                dri_tick_clk = 1'b1;
                tick_cnt++;
                if (iic_exec) exec_ticks++;
            end else if (div % 8 == 4) begin
                dri_tick_clk = 1'b0;
            end
            if (iic_exec && !exec_prev) exec_rises++;
            if (!iic_exec && exec_prev) begin
                exec_fall_tick = tick_cnt;
                if (model_en) delay = 20;
            end
            exec_prev = iic_exec;
            if (delay > 0) begin
                delay--;
            end else if (delay == 0) begin
                iic_done   = 1'b1;
                iic_data_r = model_rdata;
                iic_ack    = model_ack;
                hold       = 8;
                delay      = -1;
            end
            if (hold > 0) begin
                hold--;
                if (hold == 0) iic_done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        #3;
    endtask

    task automatic wait_gnt(input string tag);
        int n;
        n = 0;
        while (gnt == '0 && n < 40) begin
            cycle();
            n++;
        end
        check({tag, " gnt wait"}, 32'(gnt != '0), 1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (req_done == '0 && n < 400) begin
            cycle();
            n++;
        end
        check({tag, " done wait"}, 32'(req_done != '0), 1);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        repeat (2) cycle();
        sys_rst = 1'b0;
        cycle();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin : stim
        #1;
        sys_rst = 1'b1;
        repeat (2) cycle();
        check("rst gnt", gnt, 4'b0000);
        check("rst req_done", req_done, 4'b0000);
        check("rst exec", iic_exec, 0);
        check("rst nack/timeout", {nack, timeout}, 2'b00);
        check("rst rdata", rdata, 8'h00);
        sys_rst = 1'b0;
        cycle();

        // Single write on requester 2, 16-bit address.
        req_addr[47:32]  = 16'h0123;
        req_wdata[23:16] = 8'hA5;
        req_bit_ctrl[2]  = 1'b1;
        req_rh_wl[2]     = 1'b0;
        e_rises0 = exec_rises;
        e_ticks0 = exec_ticks;
        req = 4'b0100;
        cycle();
        check("wr gnt one cycle", gnt, 4'b0100);
        check("wr iic_addr", iic_addr, 16'h0123);
        check("wr iic_data_w", iic_data_w, 8'hA5);
        check("wr ctrl", {iic_rh_wl, iic_bit_ctrl}, 2'b01);
        req_addr[47:32] = 16'hFFFF;
        wait_done("wr");
        check("wr req_done", req_done, 4'b0100);
        check("wr nack/timeout", {nack, timeout}, 2'b00);
        check("wr exec pulses", exec_rises - e_rises0, 1);
        check("wr exec ticks", exec_ticks - e_ticks0, 1);
        check("wr addr stable", iic_addr, 16'h0123);
        req = 4'b0000;
        cycle();
        check("wr done pulse width", req_done, 4'b0000);
        check("wr gnt cleared", gnt, 4'b0000);

        // Read on requester 0.
        req_rh_wl[0]    = 1'b1;
        req_addr[15:0]  = 16'h0042;
        model_rdata     = 8'h3C;
        model_ack       = 1'b0;
        req = 4'b0001;
        wait_gnt("rd");
        check("rd gnt", gnt, 4'b0001);
        check("rd iic_rh_wl", iic_rh_wl, 1);
        check("rd iic_addr", iic_addr, 16'h0042);
        wait_done("rd");
        check("rd req_done", req_done, 4'b0001);
        check("rd rdata", rdata, 8'h3C);
        check("rd nack", nack, 0);
        req = 4'b0000;
        cycle();

        // NACKed write on requester 1: rdata must keep the last read value.
        req_rh_wl[1] = 1'b0;
        model_rdata  = 8'h77;
        model_ack    = 1'b1;
        req = 4'b0010;
        wait_gnt("nack");
        wait_done("nack");
        check("nack req_done", req_done, 4'b0010);
        check("nack nack/timeout", {nack, timeout}, 2'b10);
        check("nack rdata kept", rdata, 8'h3C);
        req = 4'b0000;
        model_ack = 1'b0;
        cycle();

        // Contention from reset priority: 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        wait_gnt("rr");
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'(1 << (i % 4));
            check($sformatf("rr gnt #%0d", i), gnt, exp_g);
            wait_done("rr");
            check($sformatf("rr done #%0d", i), req_done, exp_g);
            if (i == 4) req = 4'b0000;
            cycle();
        end
        check("rr idle after drop", gnt, 4'b0000);

        // Stuck driver: watchdog fires 16 ticks after launch.
        model_en = 1'b0;
        req_rh_wl[3] = 1'b0;
        req = 4'b1000;
        wait_gnt("stuck");
        wait_done("stuck");
        check("stuck req_done", req_done, 4'b1000);
        check("stuck ticks", tick_cnt - exec_fall_tick, 16);
        check("stuck nack/timeout", {nack, timeout}, 2'b11);
        req = 4'b0000;
        cycle();

        // Reset while busy, then pending requests 1 and 3 resolve to 1 first.
        req = 4'b0100;
        wait_gnt("rstb");
        repeat (40) cycle();
        check("rstb busy", {gnt, iic_exec}, 5'b01000);
        req = 4'b1010;
        sys_rst = 1'b1;
        #1;
        check("rstb gnt/done", {gnt, req_done}, 8'h00);
        check("rstb exec/nack/timeout", {iic_exec, nack, timeout}, 3'b000);
        check("rstb rdata", rdata, 8'h00);
        check("rstb cmd", {iic_rh_wl, iic_bit_ctrl, iic_addr, iic_data_w}, 26'h0);
        cycle();
        sys_rst = 1'b0;
        model_en = 1'b1;
        wait_gnt("rstb after");
        check("rstb first grant", gnt, 4'b0010);
        wait_done("rstb after");
        check("rstb req_done", req_done, 4'b0010);
        req = 4'b0000;
        repeat (2) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
